// File: rtl/shift_seq_ctrl.sv
// Command sequencer for an 8-bit shift register: load, shift n times, capture Q, return result.
// Latency: RESP entered n+2 edges after accept; backpressure: holds RESP until RES_READY, CMD_READY only in IDLE.
module shift_seq_ctrl #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             CMD_VALID,
    output logic             CMD_READY,
    input  logic [WIDTH-1:0] CMD_DATA,
    input  logic             CMD_DIR,
    input  logic [CNT_W-1:0] CMD_CNT,
    input  logic [WIDTH-1:0] CMD_SER,
    output logic             SR_LOAD,
    output logic             SR_SHIFT,
    output logic             SR_DIR,
    output logic             SR_SER_IN,
    output logic [WIDTH-1:0] SR_DATA,
    input  logic [WIDTH-1:0] SR_Q,
    output logic             RES_VALID,
    input  logic             RES_READY,
    output logic [WIDTH-1:0] RES_DATA,
    output logic             BUSY
);

    localparam int NW = $clog2(WIDTH + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SHIFT,
        S_CAPT,
        S_RESP
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             dir_q, dir_d;
    logic [WIDTH-1:0] ser_q, ser_d;
    logic [NW-1:0]    n_q, n_d;
    logic [NW-1:0]    k_q, k_d;
    logic [NW-1:0]    k_inc;
    logic [WIDTH-1:0] ser_sh;

    logic             cmd_ready_q, cmd_ready_d;
    logic             busy_q, busy_d;
    logic             sr_load_q, sr_load_d;
    logic             sr_shift_q, sr_shift_d;
    logic             sr_dir_q, sr_dir_d;
    logic             sr_ser_q, sr_ser_d;
    logic [WIDTH-1:0] sr_data_q, sr_data_d;
    logic             res_valid_q, res_valid_d;
    logic [WIDTH-1:0] res_data_q, res_data_d;

    always_comb begin
        state_d    = state_q;
        data_d     = data_q;
        dir_d      = dir_q;
        ser_d      = ser_q;
        n_d        = n_q;
        k_d        = k_q;
        res_data_d = res_data_q;
        k_inc      = k_q + NW'(1);

        case (state_q)
            S_IDLE: begin
                if (CMD_VALID && cmd_ready_q) begin
                    data_d  = CMD_DATA;
                    dir_d   = CMD_DIR;
                    ser_d   = CMD_SER;
                    n_d     = (int'(CMD_CNT) > WIDTH) ? NW'(WIDTH) : NW'(CMD_CNT);
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                k_d     = '0;
                state_d = (n_q == '0) ? S_CAPT : S_SHIFT;
            end
            S_SHIFT: begin
                k_d = k_inc;
                if (k_inc == n_q) begin
                    state_d = S_CAPT;
                end
            end
            S_CAPT: begin
                res_data_d = SR_Q;
                state_d    = S_RESP;
            end
            S_RESP: begin
                if (res_valid_q && RES_READY) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Outputs are decoded from the next state so they are registered yet aligned with the state.
        ser_sh      = ser_d >> k_d;
        sr_load_d   = 1'b0;
        sr_shift_d  = 1'b0;
        sr_dir_d    = 1'b0;
        sr_ser_d    = 1'b0;
        sr_data_d   = '0;
        cmd_ready_d = (state_d == S_IDLE);
        busy_d      = (state_d != S_IDLE);
        res_valid_d = (state_d == S_RESP);

        case (state_d)
            S_LOAD: begin
                sr_load_d = 1'b1;
                sr_data_d = data_d;
            end
            S_SHIFT: begin
                sr_shift_d = 1'b1;
                sr_dir_d   = dir_d;
                sr_ser_d   = ser_sh[0];
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= S_IDLE;
            data_q      <= '0;
            dir_q       <= 1'b0;
            ser_q       <= '0;
            n_q         <= '0;
            k_q         <= '0;
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            sr_load_q   <= 1'b0;
            sr_shift_q  <= 1'b0;
            sr_dir_q    <= 1'b0;
            sr_ser_q    <= 1'b0;
            sr_data_q   <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            data_q      <= data_d;
            dir_q       <= dir_d;
            ser_q       <= ser_d;
            n_q         <= n_d;
            k_q         <= k_d;
            cmd_ready_q <= cmd_ready_d;
            busy_q      <= busy_d;
            sr_load_q   <= sr_load_d;
            sr_shift_q  <= sr_shift_d;
            sr_dir_q    <= sr_dir_d;
            sr_ser_q    <= sr_ser_d;
            sr_data_q   <= sr_data_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
        end
    end

    assign CMD_READY = cmd_ready_q;
    assign BUSY      = busy_q;
    assign SR_LOAD   = sr_load_q;
    assign SR_SHIFT  = sr_shift_q;
    assign SR_DIR    = sr_dir_q;
    assign SR_SER_IN = sr_ser_q;
    assign SR_DATA   = sr_data_q;
    assign RES_VALID = res_valid_q;
    assign RES_DATA  = res_data_q;

endmodule
